// File: rtl/if_prefetch.sv
// Instruction prefetch unit: credit-limited fetch toward ROM, in-order response buffer toward decode.
// Optional macro IF_PREFETCH_PERF_EN adds perf_drop_cnt_o (flushed entries + discarded responses).
module if_prefetch #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_addr_i,
    output logic              rom_req_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic              rom_gnt_i,
    input  logic              rom_rvalid_i,
    input  logic [INST_W-1:0] rom_data_i,
    output logic              id_valid_o,
    input  logic              id_ready_i,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic [INST_W-1:0] id_inst_o
`ifdef IF_PREFETCH_PERF_EN
    ,
    output logic [31:0]       perf_drop_cnt_o
`endif
);

    localparam int                PW       = $clog2(DEPTH);
    localparam int                CW       = PW + 1;
    localparam logic [ADDR_W-1:0] PC_INC   = ADDR_W'(INST_W / 8);
    localparam logic [CW-1:0]     ZERO_C   = {CW{1'b0}};
    localparam logic [CW-1:0]     ONE_C    = CW'(1);
    localparam logic [PW-1:0]     ZERO_P   = {PW{1'b0}};
    localparam logic [PW-1:0]     ONE_P    = PW'(1);

    logic [ADDR_W-1:0] r_pc, r_rsp_pc;
    logic [CW-1:0]     r_count, r_out, r_drop;
    logic [PW-1:0]     r_rd_ptr, r_wr_ptr;
    logic [INST_W-1:0] r_mem_inst [DEPTH];
    logic [ADDR_W-1:0] r_mem_pc   [DEPTH];
    logic              r_id_valid;
    logic [ADDR_W-1:0] r_id_pc;
    logic [INST_W-1:0] r_id_inst;

    logic              w_credit, w_gnt, w_rsp, w_push, w_pop, w_drop_rsp;
    logic [CW-1:0]     w_kept, w_count_nxt, w_out_nxt, w_drop_nxt;
    logic [PW-1:0]     w_rd_nxt, w_wr_nxt;
    logic [ADDR_W-1:0] w_pc_nxt, w_rsp_pc_nxt, w_head_pc;
    logic [INST_W-1:0] w_head_inst;

    // Drop-pending requests still occupy credit, so they are part of r_out.
    assign w_credit   = ({1'b0, r_count} + {1'b0, r_out}) < (CW + 1)'(DEPTH);
    assign rom_req_o  = !rst && !branch_flag_i && w_credit;
    assign rom_addr_o = r_pc;
    assign w_gnt      = rom_req_o && rom_gnt_i;
    assign w_rsp      = rom_rvalid_i && (r_out != ZERO_C);
    assign w_drop_rsp = w_rsp && (branch_flag_i || (r_drop != ZERO_C));
    assign w_push     = w_rsp && !branch_flag_i && (r_drop == ZERO_C);
    assign w_pop      = r_id_valid && id_ready_i;
    assign w_kept     = w_pop ? (r_count - ONE_C) : r_count;

    assign id_valid_o = r_id_valid;
    assign id_pc_o    = r_id_pc;
    assign id_inst_o  = r_id_inst;

    // Next-state for fetch PC, buffer pointers and request bookkeeping.
    always_comb begin
        w_pc_nxt     = r_pc;
        w_rsp_pc_nxt = r_rsp_pc;
        w_count_nxt  = w_kept;
        w_rd_nxt     = r_rd_ptr;
        w_wr_nxt     = r_wr_ptr;
        w_out_nxt    = r_out;
        w_drop_nxt   = r_drop;
        if (branch_flag_i) begin
            // Every request still in flight after this cycle belongs to the old path.
            w_pc_nxt     = branch_target_addr_i;
            w_rsp_pc_nxt = branch_target_addr_i;
            w_count_nxt  = ZERO_C;
            w_rd_nxt     = ZERO_P;
            w_wr_nxt     = ZERO_P;
            w_out_nxt    = w_rsp ? (r_out - ONE_C) : r_out;
            w_drop_nxt   = w_rsp ? (r_out - ONE_C) : r_out;
        end else begin
            w_pc_nxt     = w_gnt ? (r_pc + PC_INC) : r_pc;
            w_rsp_pc_nxt = w_push ? (r_rsp_pc + PC_INC) : r_rsp_pc;
            w_count_nxt  = w_push ? (w_kept + ONE_C) : w_kept;
            w_rd_nxt     = w_pop ? (r_rd_ptr + ONE_P) : r_rd_ptr;
            w_wr_nxt     = w_push ? (r_wr_ptr + ONE_P) : r_wr_ptr;
            if (w_gnt && !w_rsp) begin
                w_out_nxt = r_out + ONE_C;
            end else if (!w_gnt && w_rsp) begin
                w_out_nxt = r_out - ONE_C;
            end else begin
                w_out_nxt = r_out;
            end
            w_drop_nxt   = w_drop_rsp ? (r_drop - ONE_C) : r_drop;
        end
    end

    // Next head presented to decode; a push into an empty buffer bypasses storage.
    always_comb begin
        w_head_pc   = r_id_pc;
        w_head_inst = r_id_inst;
        if (w_push && (w_kept == ZERO_C)) begin
            w_head_pc   = r_rsp_pc;
            w_head_inst = rom_data_i;
        end else if (w_count_nxt != ZERO_C) begin
            w_head_pc   = r_mem_pc[w_rd_nxt];
            w_head_inst = r_mem_inst[w_rd_nxt];
        end else begin
            w_head_pc   = r_id_pc;
            w_head_inst = r_id_inst;
        end
    end

    // Control state and registered decode-side outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_rsp_pc   <= RESET_PC;
            r_count    <= ZERO_C;
            r_out      <= ZERO_C;
            r_drop     <= ZERO_C;
            r_rd_ptr   <= ZERO_P;
            r_wr_ptr   <= ZERO_P;
            r_id_valid <= 1'b0;
            r_id_pc    <= {ADDR_W{1'b0}};
            r_id_inst  <= {INST_W{1'b0}};
        end else begin
            r_pc       <= w_pc_nxt;
            r_rsp_pc   <= w_rsp_pc_nxt;
            r_count    <= w_count_nxt;
            r_out      <= w_out_nxt;
            r_drop     <= w_drop_nxt;
            r_rd_ptr   <= w_rd_nxt;
            r_wr_ptr   <= w_wr_nxt;
            r_id_valid <= (w_count_nxt != ZERO_C);
            r_id_pc    <= w_head_pc;
            r_id_inst  <= w_head_inst;
        end
    end

    // Buffer storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_inst[r_wr_ptr] <= rom_data_i;
            r_mem_pc[r_wr_ptr]   <= r_rsp_pc;
        end
    end

`ifdef IF_PREFETCH_PERF_EN
    logic [31:0] r_perf;
    logic [31:0] w_perf_inc;
    logic [32:0] w_perf_sum;

    assign w_perf_inc      = branch_flag_i ? (32'(w_kept) + 32'(w_rsp)) : 32'(w_drop_rsp);
    assign w_perf_sum      = {1'b0, r_perf} + {1'b0, w_perf_inc};
    assign perf_drop_cnt_o = r_perf;

    // Saturating count of work thrown away by redirects.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf <= 32'd0;
        end else if (w_perf_sum[32]) begin
            r_perf <= 32'hFFFF_FFFF;
        end else begin
            r_perf <= w_perf_sum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_if_prefetch.sv
// Randomized scoreboard bench for if_prefetch: epoch-tagged ROM model, in-order expected queue,
// independent monitor comparing every decode handshake.
module tb_if_prefetch;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        branch_flag_i = 1'b0;
    logic [31:0] branch_target_addr_i = 32'd0;
    logic        rom_req_o;
    logic [31:0] rom_addr_o;
    logic        rom_gnt_i = 1'b0;
    logic        rom_rvalid_i = 1'b0;
    logic [31:0] rom_data_i = 32'd0;
    logic        id_valid_o;
    logic        id_ready_i = 1'b0;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
`ifdef IF_PREFETCH_PERF_EN
    logic [31:0] perf_drop_cnt_o;
`endif

    if_prefetch #(.ADDR_W(32), .INST_W(32), .DEPTH(DEPTH), .RESET_PC(32'd0)) dut (
        .clk(clk), .rst(rst),
        .branch_flag_i(branch_flag_i), .branch_target_addr_i(branch_target_addr_i),
        .rom_req_o(rom_req_o), .rom_addr_o(rom_addr_o), .rom_gnt_i(rom_gnt_i),
        .rom_rvalid_i(rom_rvalid_i), .rom_data_i(rom_data_i),
        .id_valid_o(id_valid_o), .id_ready_i(id_ready_i),
        .id_pc_o(id_pc_o), .id_inst_o(id_inst_o)
`ifdef IF_PREFETCH_PERF_EN
        , .perf_drop_cnt_o(perf_drop_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int epoch; int cyc; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;

    req_t        pend[$];
    ent_t        mq[$];
    int          tests = 0, fails = 0;
    int          cyc = 0;
    int          epoch = 0;
    int          grants = 0;
    int          first_grant = -1;
    int          first_valid = -1;
    bit          popped_now = 1'b0;
    logic [31:0] mpc = 32'd0;
    logic [31:0] model_perf = 32'd0;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares the decode-side stream against the expected queue.
    always @(posedge clk) begin
        #7;
        popped_now = 1'b0;
        if (rst) begin
            first_valid = -1;
        end else begin
            check_eq("id_valid", {31'd0, id_valid_o}, {31'd0, mq.size() != 0});
            if (id_valid_o && id_ready_i && mq.size() != 0) begin
                ent_t e;
                e = mq.pop_front();
                check_eq("id_pc", id_pc_o, e.pc);
                check_eq("id_inst", id_inst_o, e.inst);
                popped_now = 1'b1;
                if (first_valid < 0) first_valid = cyc;
            end
        end
    end

    // One clock of stimulus plus reference-model update for what happened at that edge.
    task automatic step(input bit rdy, input bit br, input logic [31:0] tgt, input int pg, input int pr);
        @(posedge clk);
        #2;
        id_ready_i           = rdy;
        branch_flag_i        = br;
        branch_target_addr_i = br ? tgt : $urandom();
        rom_gnt_i            = ($urandom_range(99) < pg);
        if (pend.size() > 0 && pend[0].cyc < cyc && $urandom_range(99) < pr) begin
            rom_rvalid_i = 1'b1;
            rom_data_i   = rom_word(pend[0].addr);
        end else begin
            rom_rvalid_i = 1'b0;
            rom_data_i   = $urandom();
        end
        #6;
        if (rom_req_o && rom_gnt_i)
            check_eq("credit", {31'd0, (pend.size() + mq.size() + int'(popped_now)) < DEPTH}, 32'd1);
        if (br) begin
            check_eq("no_req_on_branch", {31'd0, rom_req_o}, 32'd0);
            model_perf += 32'(mq.size());
            mq.delete();
            epoch++;
            mpc = tgt;
        end
        if (rom_rvalid_i) begin
            req_t r;
            r = pend.pop_front();
            if (r.epoch == epoch) mq.push_back('{pc: r.addr, inst: rom_word(r.addr)});
            else model_perf += 32'd1;
        end
        if (rom_req_o && rom_gnt_i) begin
            check_eq("fetch_addr", rom_addr_o, mpc);
            pend.push_back('{addr: mpc, epoch: epoch, cyc: cyc});
            if (first_grant < 0) first_grant = cyc;
            grants++;
            mpc = mpc + 32'd4;
        end
    endtask

    task automatic do_reset(input bit chk);
        @(posedge clk);
        #2;
        rst = 1'b1; id_ready_i = 1'b0; branch_flag_i = 1'b0; rom_gnt_i = 1'b0; rom_rvalid_i = 1'b0;
        @(posedge clk);
        #6;
        if (chk) begin
            check_eq("rst_rom_req", {31'd0, rom_req_o}, 32'd0);
            check_eq("rst_rom_addr", rom_addr_o, 32'd0);
            check_eq("rst_id_valid", {31'd0, id_valid_o}, 32'd0);
            check_eq("rst_id_pc", id_pc_o, 32'd0);
            check_eq("rst_id_inst", id_inst_o, 32'd0);
        end
        pend.delete(); mq.delete();
        mpc = 32'd0; epoch = 0; grants = 0; first_grant = -1; model_perf = 32'd0;
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic drain_and_check();
        repeat (30) step(1'b1, 1'b0, 32'd0, 0, 100);
        check_eq("drained_buffer", 32'(mq.size()), 32'd0);
        check_eq("drained_pending", 32'(pend.size()), 32'd0);
`ifdef IF_PREFETCH_PERF_EN
        check_eq("perf_drop_cnt", perf_drop_cnt_o, model_perf);
`endif
    endtask

    initial begin
        do_reset(1'b1);

        // Streaming: full grant/response rate, decode always ready.
        repeat (12) step(1'b1, 1'b0, 32'd0, 100, 100);
        check_eq("first_valid_latency", 32'(first_valid - first_grant), 32'd2);
        drain_and_check();

        // Decode stalled: credit must cap grants at DEPTH.
        do_reset(1'b0);
        repeat (15) step(1'b0, 1'b0, 32'd0, 100, 100);
        check_eq("grants_while_stalled", 32'(grants), 32'(DEPTH));
        check_eq("req_low_when_full", {31'd0, rom_req_o}, 32'd0);
        check_eq("head_pc_held", id_pc_o, 32'd0);
        drain_and_check();

        // Redirect with two requests outstanding.
        do_reset(1'b0);
        step(1'b1, 1'b0, 32'd0, 100, 0);
        step(1'b1, 1'b0, 32'd0, 100, 0);
        step(1'b1, 1'b1, 32'h0000_0100, 100, 0);
        repeat (10) step(1'b1, 1'b0, 32'd0, 100, 100);
        drain_and_check();

        // Redirect coinciding with a head pop and an arriving response.
        do_reset(1'b0);
        repeat (3) step(1'b0, 1'b0, 32'd0, 100, 100);
        step(1'b1, 1'b1, 32'h0000_0100, 0, 100);
        repeat (10) step(1'b1, 1'b0, 32'd0, 100, 100);
        drain_and_check();

        // Fetch across the top of the address space.
        do_reset(1'b0);
        step(1'b1, 1'b1, 32'hFFFF_FFF8, 100, 100);
        repeat (10) step(1'b1, 1'b0, 32'd0, 100, 100);
        drain_and_check();

        // Randomized traffic with frequent redirects.
        for (int ph = 0; ph < 4; ph++) begin
            do_reset(1'b0);
            for (int i = 0; i < 600; i++)
                step($urandom_range(99) < 70, $urandom_range(99) < 8,
                     $urandom() & 32'hFFFF_FFFC, 70, 60);
            drain_and_check();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/if_prefetch.md
IF_PREFETCH -- requirements
Module: if_prefetch

Interface
REQ-001 Parameter ADDR_W, default 32: instruction address width.
REQ-002 Parameter INST_W, default 32: instruction width; PC increment is INST_W/8.
REQ-003 Parameter DEPTH, default 4: prefetch buffer entries; power of two, at least 2.
REQ-004 Parameter RESET_PC, default 0: first fetch address after reset.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 branch_flag_i  input  1  redirect request from decode.
REQ-008 branch_target_addr_i  input  ADDR_W  redirect target.
REQ-009 rom_req_o  output  1  fetch request valid.
REQ-010 rom_addr_o  output  ADDR_W  fetch address; held stable while rom_req_o=1 and rom_gnt_i=0.
REQ-011 rom_gnt_i  input  1  request accepted this cycle.
REQ-012 rom_rvalid_i  input  1  response valid; responses return in request order, at least 1 cycle after grant.
REQ-013 rom_data_i  input  INST_W  response instruction.
REQ-014 id_valid_o  output  1  buffer head valid toward decode.
REQ-015 id_ready_i  input  1  decode accepts head (deasserted while decode stalls).
REQ-016 id_pc_o  output  ADDR_W  address of head instruction.
REQ-017 id_inst_o  output  INST_W  head instruction.

Function
REQ-018 Fetch PC advances by INST_W/8 on every cycle with rom_req_o=1 and rom_gnt_i=1; wraps modulo 2^ADDR_W.
REQ-019 rom_req_o=1 only when (buffered entries + outstanding requests) < DEPTH and branch_flag_i=0; buffer therefore never overflows.
REQ-020 Outstanding counter increments on grant, decrements on rom_rvalid_i; simultaneous grant and rvalid leave it unchanged.
REQ-021 Each accepted response is pushed with the address of its matching request; entries are dequeued strictly in order.
REQ-022 id_valid_o=1 iff buffer non-empty; head pops on id_valid_o=1 and id_ready_i=1; outputs are registered head contents.
REQ-023 Latency: grant at cycle t, rvalid at t+1 → id_valid_o with that instruction at t+2 (buffer previously empty).
REQ-024 Simultaneous push and pop on a full or empty buffer preserve count and order.
REQ-025 On branch_flag_i=1: pop in that cycle still takes effect, then buffer emptied, fetch PC loaded with branch_target_addr_i, no request issued that cycle.
REQ-026 Requests outstanding at the redirect are loaded into a drop counter; their responses, including one arriving in the redirect cycle, are discarded, not pushed.
REQ-027 A redirect arriving while the drop counter is non-zero adds the new outstanding count to the remaining drop count.
REQ-028 New requests may issue during draining; credit check counts drop-pending requests as outstanding.

Reset
REQ-029 While rst=1 at a clock edge: fetch PC=RESET_PC, buffer empty, outstanding=0, drop=0.
REQ-030 Reset outputs: rom_req_o=0, rom_addr_o=RESET_PC, id_valid_o=0, id_pc_o=0, id_inst_o=0.
REQ-031 Reset mid-operation abandons in-flight requests; responses after reset release are pushed as new (memory is reset with the block).

Configuration
REQ-032 Macro IF_PREFETCH_PERF_EN defined: adds output perf_drop_cnt_o (32 bits), counting flushed buffer entries plus discarded responses, saturating at all-ones, cleared by rst.
REQ-033 Macro undefined: port and counter absent; all other behaviour identical.

Verification
REQ-034 Reset release, gnt=1 every cycle, rvalid 1 cycle after grant, id_ready_i=1 → id_pc_o sequence 0x0,0x4,0x8,… first valid 2 cycles after first grant.
REQ-035 id_ready_i=0 indefinitely, DEPTH=4 → exactly 4 grants issued, rom_req_o then held 0, id_pc_o stays 0x0.
REQ-036 Branch to 0x100 with 2 requests outstanding → those 2 responses dropped, next id_pc_o=0x100, no stale instruction visible.
REQ-037 Branch in same cycle as head pop and rvalid → popped entry consumed once, rvalid data discarded, next fetch address 0x100.
REQ-038 Fetch from PC 0xFFFFFFFC (ADDR_W=32) → next id_pc_o 0x0.
REQ-039 With IF_PREFETCH_PERF_EN, redirect with 3 buffered + 1 outstanding → perf_drop_cnt_o increments by 4.
